// File: rtl/memio_pkg.sv
// +------------------------------------------------------------------+
// | memio_pkg: shared address map, byte type and byte-lane helper     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package memio_pkg;
   typedef logic [7:0] byte_t;

   localparam logic [1:0]  IO_SEL    = 2'b11;
   localparam logic [31:0] UART_ADDR = 32'h0003_0000;
   localparam logic [31:0] CLK_ADDR  = 32'h0003_0004;
   localparam logic [31:0] RAM_LIMIT = 32'h0002_0000;

   function automatic byte_t word_byte(input logic [31:0] w, input logic [1:0] idx);
      return w[{idx, 3'b000} +: 8];
   endfunction
endpackage

`default_nettype wire

// File: rtl/memio_fifo.sv
// +------------------------------------------------------------------+
// | memio_fifo: synchronous byte FIFO, power-of-two depth, async rst  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module memio_fifo import memio_pkg::*; #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  byte_t                    i_din,
   input  logic                     i_pop,
   output byte_t                    o_dout,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int c_AW = $clog2(DEPTH);
   localparam logic [c_AW:0] c_FULL = DEPTH[c_AW:0];

   byte_t           r_mem [0:DEPTH-1];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_count;
   logic            w_do_pop;
   logic            w_do_push;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == c_FULL);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
      end
   end
endmodule

`default_nettype wire

// File: rtl/mem_io_resp.sv
// +------------------------------------------------------------------+
// | mem_io_resp: byte RAM + UART/cycle-counter I/O responder, 1-cycle |
// | reads. Optional RX queue enabled by macro MEMIO_RX_EN. Rev 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

module mem_io_resp import memio_pkg::*; #(
   parameter int RAM_AW      = 17,
   parameter int TXQ_DEPTH   = 16,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        halt,
   output logic        tx_overflow
);
   localparam int c_CW = $clog2(TXQ_DEPTH) + 1;

   byte_t            r_ram [0:2**RAM_AW-1];
   byte_t            r_ram_q;
   byte_t            r_io_q;
   logic             r_ram_rd;
   logic [31:0]      r_cnt;
   logic [31:0]      r_snap;
   logic             r_halt;
   logic             r_ovf;
   logic             r_full;

   logic             w_io_sel, w_ram_sel, w_uart_sel, w_clk_sel, w_halt_wr;
   logic             w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
   byte_t            w_tx_din, w_tx_head, w_rx_byte;
   logic [c_CW-1:0]  w_tx_count;
   logic             w_unused_rx;

   assign w_io_sel   = (mem_a[17:16] == IO_SEL);
   assign w_ram_sel  = !w_io_sel && (mem_a < RAM_LIMIT);
   assign w_uart_sel = w_io_sel && (mem_a == UART_ADDR);
   assign w_clk_sel  = w_io_sel && (mem_a[31:2] == CLK_ADDR[31:2]);
   assign w_halt_wr  = mem_wr && w_io_sel && (mem_a == CLK_ADDR);

   // The stop write doubles as an end-of-output marker on the UART.
   assign w_tx_push  = (mem_wr && w_uart_sel && (mem_dout != 8'h00)) || w_halt_wr;
   assign w_tx_din   = w_halt_wr ? 8'h00 : mem_dout;
   assign w_tx_pop   = tx_valid && tx_ready;

   memio_fifo #(.DEPTH(TXQ_DEPTH)) u_txq (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_tx_push),
      .i_din   (w_tx_din),
      .i_pop   (w_tx_pop),
      .o_dout  (w_tx_head),
      .o_count (w_tx_count),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty)
   );

`ifdef MEMIO_RX_EN
   logic            w_rx_pop, w_rx_full, w_rx_empty;
   byte_t           w_rx_head;
   logic [c_CW-1:0] w_rx_count;

   assign w_rx_pop = !mem_wr && w_uart_sel && !w_rx_empty;

   memio_fifo #(.DEPTH(TXQ_DEPTH)) u_rxq (
      .clk     (clk),
      .rst     (rst),
      .i_push  (rx_valid),
      .i_din   (rx_data),
      .i_pop   (w_rx_pop),
      .o_dout  (w_rx_head),
      .o_count (w_rx_count),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty)
   );

   assign w_rx_byte   = w_rx_empty ? 8'h00 : w_rx_head;
   assign w_unused_rx = ^{w_rx_count, w_rx_full};
`else
   assign w_rx_byte   = 8'h00;
   assign w_unused_rx = ^{rx_data, rx_valid};
`endif

   // RAM has no reset so it can map onto block memory.
   always_ff @(posedge clk) begin
      if (mem_wr && w_ram_sel) r_ram[mem_a[RAM_AW-1:0]] <= mem_dout;
      r_ram_q <= r_ram[mem_a[RAM_AW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_snap   <= '0;
         r_io_q   <= '0;
         r_ram_rd <= 1'b0;
         r_halt   <= 1'b0;
         r_ovf    <= 1'b0;
         r_full   <= 1'b0;
      end else begin
         r_cnt    <= r_cnt + 32'd1;
         r_full   <= (TXQ_DEPTH - int'(w_tx_count)) <= FULL_MARGIN;
         r_io_q   <= 8'h00;
         r_ram_rd <= !mem_wr && w_ram_sel;
         if (w_halt_wr) r_halt <= 1'b1;
         if (w_tx_push && w_tx_full && !w_tx_pop) r_ovf <= 1'b1;
         if (!mem_wr && w_clk_sel) begin
            if (mem_a[1:0] == 2'b00) begin
               r_snap <= r_cnt;
               r_io_q <= r_cnt[7:0];
            end else begin
               r_io_q <= word_byte(r_snap, mem_a[1:0]);
            end
         end else if (!mem_wr && w_uart_sel) begin
            r_io_q <= w_rx_byte;
         end
      end
   end

   assign mem_din        = r_ram_rd ? r_ram_q : r_io_q;
   assign tx_valid       = !w_tx_empty;
   assign tx_data        = w_tx_empty ? 8'h00 : w_tx_head;
   assign io_buffer_full = r_full;
   assign halt           = r_halt;
   assign tx_overflow    = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_mem_io_resp.sv
// +------------------------------------------------------------------+
// | tb_mem_io_resp: directed + randomized bench with reference model  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mem_io_resp;
   localparam int c_DEPTH  = 16;
   localparam int c_MARGIN = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_a = 32'h0002_0000;
   logic [7:0]  mem_dout = 8'h00;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        halt;
   logic        tx_overflow;

   mem_io_resp #(.RAM_AW(17), .TXQ_DEPTH(c_DEPTH), .FULL_MARGIN(c_MARGIN)) u_dut (
      .clk(clk), .rst(rst), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
      .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .halt(halt), .tx_overflow(tx_overflow)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   logic [7:0]  ram_m [int];
   logic [7:0]  txq_m[$];
   logic [7:0]  rxq_m[$];
   logic [7:0]  tx_seen[$];
   logic        halt_m, ovf_m, full_m;
   int unsigned cnt_m, snap_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      txq_m.delete(); rxq_m.delete();
      halt_m = 1'b0; ovf_m = 1'b0; full_m = 1'b0;
      cnt_m = 0; snap_m = 0;
   endtask

   // One clock of stimulus; the model predicts the state after the edge.
   task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input logic rdy, input logic rv, input logic [7:0] rd);
      int          sz;
      bit          pop, push, known;
      logic [7:0]  exp_din;
      mem_a = a; mem_wr = wr; mem_dout = d; tx_ready = rdy; rx_valid = rv; rx_data = rd;
      sz      = txq_m.size();
      pop     = rdy && (sz > 0);
      push    = wr && (((a == 32'h30000) && (d != 8'h00)) || (a == 32'h30004));
      known   = 1'b0;
      exp_din = 8'h00;
      if (!wr) begin
         known = 1'b1;
         if (a < 32'h20000) begin
            known   = ram_m.exists(int'(a));
            exp_din = known ? ram_m[int'(a)] : 8'h00;
         end else if (a == 32'h30000) begin
`ifdef MEMIO_RX_EN
            if (rxq_m.size() > 0) exp_din = rxq_m.pop_front();
`endif
         end else if (a >= 32'h30004 && a <= 32'h30007) begin
            if (a == 32'h30004) begin
               snap_m  = cnt_m;
               exp_din = cnt_m[7:0];
            end else begin
               exp_din = 8'((snap_m >> (8 * (a - 32'h30004))) & 32'hFF);
            end
         end
      end else if (a < 32'h20000) begin
         ram_m[int'(a)] = d;
      end
`ifdef MEMIO_RX_EN
      if (rv && rxq_m.size() < c_DEPTH) rxq_m.push_back(rd);
`endif
      full_m = (c_DEPTH - sz) <= c_MARGIN;
      if (pop) void'(txq_m.pop_front());
      if (push) begin
         if (sz == c_DEPTH && !pop) ovf_m = 1'b1;
         else txq_m.push_back((a == 32'h30004) ? 8'h00 : d);
      end
      if (wr && a == 32'h30004) halt_m = 1'b1;
      if (tx_valid && rdy) tx_seen.push_back(tx_data);
      cnt_m++;
      @(posedge clk); #1;
      if (known) chk("mem_din", {24'h0, mem_din}, {24'h0, exp_din});
      chk("tx_valid", {31'h0, tx_valid}, {31'h0, txq_m.size() > 0});
      if (txq_m.size() > 0) chk("tx_data", {24'h0, tx_data}, {24'h0, txq_m[0]});
      chk("io_buffer_full", {31'h0, io_buffer_full}, {31'h0, full_m});
      chk("halt", {31'h0, halt}, {31'h0, halt_m});
      chk("tx_overflow", {31'h0, tx_overflow}, {31'h0, ovf_m});
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(32'h0002_0000, 1'b0, 8'h00, rdy, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_a = 32'h0002_0000; mem_wr = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [31:0] addr_tab [11];
      logic [31:0] a;
      logic        wr;
      addr_tab = '{32'h0, 32'h1FFFF, 32'h30000, 32'h30004, 32'h30005, 32'h30006,
                   32'h30007, 32'h20010, 32'h40000, 32'h30008, 32'h10};
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_din", {24'h0, mem_din}, 32'h0);
      chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
      chk("rst_buf_full", {31'h0, io_buffer_full}, 32'h0);
      chk("rst_halt", {31'h0, halt}, 32'h0);
      chk("rst_overflow", {31'h0, tx_overflow}, 32'h0);
      rst = 1'b0;
      model_reset();

      // Counter: 100 cycles after release, snapshot read of all four bytes.
      idle(100, 1'b0);
      step(32'h30004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("cnt_b0_window", {31'h0, (mem_din >= 8'h63) && (mem_din <= 8'h65)}, 32'h1);
      step(32'h30005, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("cnt_b1", {24'h0, mem_din}, 32'h0);
      step(32'h30006, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      step(32'h30007, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("cnt_b3", {24'h0, mem_din}, 32'h0);

      // RAM write then read, one-cycle latency.
      step(32'h10, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
      step(32'h10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("ram_a5", {24'h0, mem_din}, 32'hA5);

      // UART output: zero byte is filtered.
      tx_seen.delete();
      step(32'h30000, 1'b1, 8'h41, 1'b1, 1'b0, 8'h00);
      step(32'h30000, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
      step(32'h30000, 1'b1, 8'h42, 1'b1, 1'b0, 8'h00);
      idle(4, 1'b1);
      chk("uart_count", tx_seen.size(), 32'd2);
      if (tx_seen.size() == 2) begin
         chk("uart_b0", {24'h0, tx_seen[0]}, 32'h41);
         chk("uart_b1", {24'h0, tx_seen[1]}, 32'h42);
      end

      // Back-pressure and overflow.
      for (int i = 0; i < 14; i++) step(32'h30000, 1'b1, 8'(i + 1), 1'b0, 1'b0, 8'h00);
      idle(1, 1'b0);
      chk("bp_full", {31'h0, io_buffer_full}, 32'h1);
      for (int i = 0; i < 3; i++) step(32'h30000, 1'b1, 8'h70, 1'b0, 1'b0, 8'h00);
      chk("bp_overflow", {31'h0, tx_overflow}, 32'h1);
      idle(20, 1'b1);

      // RX path.
      step(32'h0002_0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h37);
      step(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
`ifdef MEMIO_RX_EN
      chk("rx_first", {24'h0, mem_din}, 32'h37);
`else
      chk("rx_first", {24'h0, mem_din}, 32'h00);
`endif
      step(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("rx_second", {24'h0, mem_din}, 32'h00);

      // Stop write, then reset with bytes still queued.
      do_reset();
      step(32'h30000, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00);
      step(32'h30004, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00);
      chk("stop_halt", {31'h0, halt}, 32'h1);
      step(32'h0002_0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
      chk("stop_zero_byte", {24'h0, tx_data}, 32'h00);
      chk("stop_zero_valid", {31'h0, tx_valid}, 32'h1);
      rst = 1'b1;
      #1;
      chk("rst_async_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_async_halt", {31'h0, halt}, 32'h0);
      do_reset();

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         a  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 31)) : addr_tab[$urandom_range(0, 10)];
         wr = $urandom_range(0, 2) == 0;
         if (a >= 32'h30005 && a <= 32'h30008) wr = 1'b0;
         if (a == 32'h30004 && $urandom_range(0, 7) != 0) wr = 1'b0;
         step(a, wr, 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 255)),
              1'($urandom_range(0, 1)), (rxq_m.size() < 14) && ($urandom_range(0, 9) == 0),
              8'($urandom_range(0, 255)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

`default_nettype wire
